// File: rtl/updown_btn_ctrl_if.sv
// Button / counter bundle between the raw button source and the up/down
// button controller.
//   up, down             raw asynchronous buttons (source -> controller)
//   count                current counter value
//   up_level, down_level debounced button levels
//   step_up, step_down   one-cycle pulses: a step was applied
//   wrap                 one-cycle pulse: the applied step wrapped
//   conflict             one-cycle pulse: simultaneous requests discarded
interface updown_btn_ctrl_if #(
   parameter int CNT_W = 4
);
   logic             up;
   logic             down;
   logic [CNT_W-1:0] count;
   logic             up_level;
   logic             down_level;
   logic             step_up;
   logic             step_down;
   logic             wrap;
   logic             conflict;

   modport master (
      output up, down,
      input  count, up_level, down_level, step_up, step_down, wrap, conflict
   );

   modport slave (
      input  up, down,
      output count, up_level, down_level, step_up, step_down, wrap, conflict
   );
endinterface

// File: rtl/updown_btn_ctrl.sv
// Up/down button front end: 2-FF synchronisers, debouncers, press / hold /
// auto-repeat step generation and arbitration onto one modulo counter.
//   sys_clk  system clock, rising edge
//   sys_rst  synchronous reset, active-high
//   btn_if   slave side of updown_btn_ctrl_if (raw buttons in, counter,
//            debounced levels and event pulses out)
//
// Per-button FSM:
//   state     | meaning
//   ST_IDLE   | button released; a level rising edge issues the press step
//   ST_HELD   | pressed; hold timer running toward the first repeat step
//   ST_REPEAT | auto-repeat; a step every REPEAT_CYCLES while held
module updown_btn_ctrl #(
   parameter int DB_CYCLES     = 8,
   parameter int HOLD_CYCLES   = 64,
   parameter int REPEAT_CYCLES = 16,
   parameter int CNT_W         = 4,
   parameter int CNT_MAX       = 15
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   updown_btn_ctrl_if.slave   btn_if
);
   localparam int DB_W    = $clog2(DB_CYCLES);
   localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_REPEAT} state_e;

   // Index 0 = up button, index 1 = down button.
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       level_q, level_d;
   logic [1:0]       level_prev_q, level_prev_d;
   logic [DB_W-1:0]  db_cnt_q [2];
   logic [DB_W-1:0]  db_cnt_d [2];
   state_e           state_q [2];
   state_e           state_d [2];
   logic [TMR_W-1:0] tmr_q [2];
   logic [TMR_W-1:0] tmr_d [2];
   logic [1:0]       req;

   logic [CNT_W-1:0] count_q, count_d;
   logic             step_up_q, step_up_d;
   logic             step_down_q, step_down_d;
   logic             wrap_q, wrap_d;
   logic             conflict_q, conflict_d;

   always_comb begin
      sync1_d      = {btn_if.down, btn_if.up};
      sync2_d      = sync1_q;
      level_d      = level_q;
      level_prev_d = level_q;
      req          = '0;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         state_d[i]  = state_q[i];
         tmr_d[i]    = tmr_q[i];

         // Level only flips after DB_CYCLES consecutive mismatching samples.
         if (sync2_q[i] == level_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
            level_d[i]  = ~level_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end

         // Timers are down-counters loaded with period-1; a step fires at zero.
         case (state_q[i])
            ST_IDLE: begin
               tmr_d[i] = '0;
               if (level_q[i] && !level_prev_q[i]) begin
                  req[i]     = 1'b1;
                  state_d[i] = ST_HELD;
                  tmr_d[i]   = TMR_W'(HOLD_CYCLES - 1);
               end
            end
            ST_HELD, ST_REPEAT: begin
               if (!level_q[i]) begin
                  state_d[i] = ST_IDLE;
                  tmr_d[i]   = '0;
               end else if (tmr_q[i] == '0) begin
                  req[i]     = 1'b1;
                  state_d[i] = ST_REPEAT;
                  tmr_d[i]   = TMR_W'(REPEAT_CYCLES - 1);
               end else begin
                  tmr_d[i] = tmr_q[i] - TMR_W'(1);
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               tmr_d[i]   = '0;
            end
         endcase
      end
   end

   always_comb begin
      count_d     = count_q;
      step_up_d   = 1'b0;
      step_down_d = 1'b0;
      wrap_d      = 1'b0;
      conflict_d  = 1'b0;
      case (req)
         2'b01: begin
            step_up_d = 1'b1;
            if (count_q == CNT_W'(CNT_MAX)) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         2'b10: begin
            step_down_d = 1'b1;
            if (count_q == '0) begin
               count_d = CNT_W'(CNT_MAX);
               wrap_d  = 1'b1;
            end else begin
               count_d = count_q - CNT_W'(1);
            end
         end
         2'b11:   conflict_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         level_q      <= '0;
         level_prev_q <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= '0;
            state_q[i]  <= ST_IDLE;
            tmr_q[i]    <= '0;
         end
         count_q     <= '0;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
         wrap_q      <= 1'b0;
         conflict_q  <= 1'b0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         level_q      <= level_d;
         level_prev_q <= level_prev_d;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
            state_q[i]  <= state_d[i];
            tmr_q[i]    <= tmr_d[i];
         end
         count_q     <= count_d;
         step_up_q   <= step_up_d;
         step_down_q <= step_down_d;
         wrap_q      <= wrap_d;
         conflict_q  <= conflict_d;
      end
   end

   assign btn_if.count      = count_q;
   assign btn_if.up_level   = level_q[0];
   assign btn_if.down_level = level_q[1];
   assign btn_if.step_up    = step_up_q;
   assign btn_if.step_down  = step_down_q;
   assign btn_if.wrap       = wrap_q;
   assign btn_if.conflict   = conflict_q;
endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Testbench for updown_btn_ctrl: table of clean presses plus hand-written
// reset, bounce, auto-repeat, conflict and glitch sequences. Expected step
// events go into a queue when a press is driven and are popped by a monitor
// whenever the DUT raises a pulse.
module tb_updown_btn_ctrl;
   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   updown_btn_ctrl_if #(.CNT_W(4)) bif ();

   updown_btn_ctrl #(
      .DB_CYCLES(8), .HOLD_CYCLES(64), .REPEAT_CYCLES(16), .CNT_W(4), .CNT_MAX(15)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .btn_if  (bif)
   );

   typedef struct packed {
      logic       su;
      logic       sd;
      logic       wr;
      logic       cf;
      logic [3:0] cnt;
   } ev_t;

   typedef struct {
      bit u;
      bit d;
      int exp_cnt;
   } vec_t;

   int   n_pass  = 0;
   int   n_total = 0;
   ev_t  exp_q[$];
   ev_t  got_ev;
   ev_t  exp_ev;
   bit   mon_en  = 1'b0;
   int   model_cnt;
   int   su_seen = 0;
   int   wr_seen = 0;
   int   cf_seen = 0;
   bit   up_lvl_seen = 1'b0;
   vec_t tbl[6];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push_up();
      ev_t e;
      e = '0;
      e.su = 1'b1;
      e.wr = (model_cnt == 15);
      model_cnt = (model_cnt == 15) ? 0 : model_cnt + 1;
      e.cnt = 4'(model_cnt);
      exp_q.push_back(e);
   endtask

   task automatic push_down();
      ev_t e;
      e = '0;
      e.sd = 1'b1;
      e.wr = (model_cnt == 0);
      model_cnt = (model_cnt == 0) ? 15 : model_cnt - 1;
      e.cnt = 4'(model_cnt);
      exp_q.push_back(e);
   endtask

   task automatic push_conf();
      ev_t e;
      e = '0;
      e.cf = 1'b1;
      e.cnt = 4'(model_cnt);
      exp_q.push_back(e);
   endtask

   task automatic drain(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Clean press held for hold cycles, then idle long enough to settle.
   task automatic press(input bit u, input bit d, input int hold, input int idle);
      @(negedge sys_clk);
      bif.up   = u;
      bif.down = d;
      repeat (hold) @(negedge sys_clk);
      bif.up   = 1'b0;
      bif.down = 1'b0;
      repeat (idle) @(negedge sys_clk);
      drain("press_drain");
      check("press_count", int'(bif.count), model_cnt);
   endtask

   // 20 toggles every 3 ns, then settle to v.
   task automatic bounce_to(input bit v);
      for (int k = 0; k < 20; k++) begin
         bif.up = ~bif.up;
         #3;
      end
      bif.up = v;
   endtask

   always @(negedge sys_clk) begin
      if (mon_en) begin
         if (bif.up_level) up_lvl_seen = 1'b1;
         if (bif.step_up) su_seen++;
         if (bif.wrap) wr_seen++;
         if (bif.conflict) cf_seen++;
         if (bif.step_up || bif.step_down || bif.wrap || bif.conflict) begin
            got_ev = {bif.step_up, bif.step_down, bif.wrap, bif.conflict, bif.count};
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_event: got ev=0x%02h expected none", got_ev);
            end else begin
               exp_ev = exp_q.pop_front();
               check("event", int'(got_ev), int'(exp_ev));
            end
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int su0, wr0, cf0;

      tbl[0] = '{u: 1'b0, d: 1'b1, exp_cnt: 0};
      tbl[1] = '{u: 1'b0, d: 1'b1, exp_cnt: 15};
      tbl[2] = '{u: 1'b1, d: 1'b0, exp_cnt: 0};
      tbl[3] = '{u: 1'b1, d: 1'b0, exp_cnt: 1};
      tbl[4] = '{u: 1'b0, d: 1'b1, exp_cnt: 0};
      tbl[5] = '{u: 1'b1, d: 1'b1, exp_cnt: 0};

      // Reset with up held: fresh press after release.
      sys_rst  = 1'b1;
      bif.up   = 1'b1;
      bif.down = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(posedge sys_clk);
         #1;
         check("reset_count", int'(bif.count), 0);
         check("reset_outs", int'({bif.up_level, bif.down_level, bif.step_up,
                                   bif.step_down, bif.wrap, bif.conflict}), 0);
      end
      @(negedge sys_clk);
      sys_rst   = 1'b0;
      model_cnt = 0;
      push_up();
      mon_en    = 1'b1;
      @(posedge sys_clk);
      repeat (8) @(posedge sys_clk);
      #1;
      check("rst_level_early", int'(bif.up_level), 0);
      @(posedge sys_clk);
      #1;
      check("rst_level_rise", int'(bif.up_level), 1);
      check("rst_count_before", int'(bif.count), 0);
      @(posedge sys_clk);
      #1;
      check("rst_count_step", int'(bif.count), 1);
      check("rst_step_up", int'(bif.step_up), 1);
      @(negedge sys_clk);
      bif.up = 1'b0;
      repeat (25) @(negedge sys_clk);
      drain("rst_drain");

      // Table of clean single presses, including both wraps and a conflict.
      for (int i = 0; i < 6; i++) begin
         if (tbl[i].u && tbl[i].d) push_conf();
         else if (tbl[i].u)        push_up();
         else                      push_down();
         press(tbl[i].u, tbl[i].d, 12, 25);
         check("vec_count", int'(bif.count), tbl[i].exp_cnt);
      end

      // Bounce rejection: 18 bouncy presses from 0.
      su0 = su_seen;
      wr0 = wr_seen;
      for (int k = 0; k < 18; k++) begin
         push_up();
         @(negedge sys_clk);
         bounce_to(1'b1);
         #200;
         bounce_to(1'b0);
         repeat (25) @(negedge sys_clk);
      end
      drain("bounce_drain");
      check("bounce_steps", su_seen - su0, 18);
      check("bounce_wraps", wr_seen - wr0, 1);
      check("bounce_count", int'(bif.count), 2);

      // Auto-repeat from 0: press + hold + 3 repeats, nothing on release.
      push_down();
      press(1'b0, 1'b1, 12, 25);
      push_down();
      press(1'b0, 1'b1, 12, 25);
      for (int k = 0; k < 5; k++) push_up();
      press(1'b1, 1'b0, 8 + 1 + 64 + 3 * 16 + 5, 30);
      check("repeat_count", int'(bif.count), 5);

      // Conflict at 7.
      push_up();
      press(1'b1, 1'b0, 12, 25);
      push_up();
      press(1'b1, 1'b0, 12, 25);
      cf0 = cf_seen;
      push_conf();
      press(1'b1, 1'b1, 12, 25);
      check("conflict_pulses", cf_seen - cf0, 1);
      check("conflict_count", int'(bif.count), 7);

      // Short glitch is rejected.
      up_lvl_seen = 1'b0;
      press(1'b1, 1'b0, 5, 25);
      check("glitch_level", int'(up_lvl_seen), 0);
      check("glitch_count", int'(bif.count), 7);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/updown_btn_ctrl.md
Name: updown_btn_ctrl

Overview:
- Front-end controller for the up/down counter and 7-segment datapath.
- Synchronises and debounces the raw `up`/`down` buttons, and generates step requests on press and on hold-to-auto-repeat.
- Arbitrates the two requesters onto a single modulo counter; its outputs feed the display encoder.
- Replaces ad-hoc edge logic in the top level.

Parameters:
- DB_CYCLES, 8, consecutive stable cycles required before the debounced level changes (>=2).
- HOLD_CYCLES, 64, cycles a button must stay held after its press step before auto-repeat starts.
- REPEAT_CYCLES, 16, cycles between auto-repeat steps.
- CNT_W, 4, counter width.
- CNT_MAX, 15, maximum count value (<= 2^CNT_W-1).

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- up  in  1  raw, asynchronous, bouncing up button.
- down  in  1  raw, asynchronous, bouncing down button.
- count  out  CNT_W  current counter value.
- up_level  out  1  debounced up level.
- down_level  out  1  debounced down level.
- step_up  out  1  one-cycle pulse: an increment was applied this cycle.
- step_down  out  1  one-cycle pulse: a decrement was applied this cycle.
- wrap  out  1  one-cycle pulse: the applied step wrapped (CNT_MAX->0 or 0->CNT_MAX).
- conflict  out  1  one-cycle pulse: simultaneous up and down requests were discarded.

Behaviour:
- One clock domain, one synchronous active-high reset. Reset is sampled on the clock edge only.
- Reset values: count=0, all levels and pulses=0. Synchroniser FFs, debounce counters, FSMs and timers are cleared.
- Reset mid-operation: everything is cleared on that edge, including pending repeats.
  - A button still held when reset deasserts is treated as a fresh press. Its debounced level rises after the normal latency and issues one step.
- Synchroniser: 2 FFs per button. The debounce input is the second stage.
- Debouncer (per button), clock-for-clock identical for both:
  - Holds a counter of 0..DB_CYCLES-1.
  - When the synced value equals the level, the counter is cleared.
  - Otherwise the counter increments. On the cycle it equals DB_CYCLES-1 with the mismatch still present, the level flips and the counter clears.
  - Any glitch back clears the counter.
  - Latency: a clean raw transition stable from edge E appears on `*_level` at edge E+DB_CYCLES+1.
- Per-button FSM states: IDLE, HELD, REPEAT.
  - IDLE: a level rising edge (level=1, previous level=0) raises a step request and goes to HELD; the timer clears.
  - HELD: the timer counts while the level is 1. When it reaches HOLD_CYCLES-1, raise a request, clear the timer and go to REPEAT.
  - REPEAT: the timer counts. At REPEAT_CYCLES-1, raise a request and clear the timer.
  - HELD/REPEAT: level=0 -> IDLE. No step is issued on release.
- Arbiter/counter, registered one cycle after the request:
  - Up request only: count = (count==CNT_MAX) ? 0 : count+1. Pulses step_up, and wrap if it wrapped.
  - Down request only: count = (count==0) ? CNT_MAX : count-1. Pulses step_down, and wrap if it wrapped.
  - Both requests in the same cycle: count unchanged, conflict=1, no step pulses. Both FSMs still advance normally.
- Press-to-count latency: count changes at edge E+DB_CYCLES+2 after the raw signal goes stable at E.
- step_*, wrap and conflict are registered and high for exactly one cycle per event.

Test Plan:
- Reset: assert sys_rst for 2 cycles with up=1 held -> during reset count=0 and all outputs 0. After release, up_level rises at 9 cycles (DB_CYCLES+1) and count=1 at 10 cycles.
- Bounce rejection: up toggles 20 times at a 3 ns period then settles to 1, holds 200 ns, then bounces back to 0. Repeat 18 times from count=0:
  - exactly 18 step_up pulses;
  - count sequence 1..15,0,1,2;
  - one wrap pulse, at 15->0.
- Down wrap: from count=0, one clean down press -> count=15, step_down=1 and wrap=1 in the same cycle.
- Auto-repeat: hold up clean for 8+1+64+3x16+5 cycles from count=0 -> steps at the press plus 1 hold plus 3 repeats, so count=5. Release produces no extra step.
- Conflict: drive up and down identical clean presses on the same edge with count=7 -> conflict pulses once, count stays 7, no step pulses.
- Glitch: a 5-cycle up pulse (< DB_CYCLES) -> up_level stays 0 and count unchanged.
